// File: rtl/lsu_split_mem.sv
// Load/store unit: splits 1..8 byte accesses that cross a bus word into two aligned beats and reassembles loads.
// Latency: resp_valid 3 cycles after accept (aligned), 5 (split), 1 (no-op/illegal), plus any bus stalls.
// Backpressure: req_ready only in IDLE; each beat is held until mem_req_ready; bus responses awaited indefinitely.
module lsu_split_mem #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] CLINT_BASE = 'h200_0000,
  parameter logic [ADDR_W-1:0] CLINT_END  = 'h200_BFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_memop,
  input  logic                req_wen,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                clint_we,
  output logic                clint_re
);
  localparam int B    = DATA_W / 8;
  localparam int OFFW = $clog2(B);
  localparam int B2   = 2 * B;
  localparam int DW2  = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        memop_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic              k_q;
  logic              err_q;
  logic              clint_we_q;
  logic              clint_re_q;
  logic [DATA_W-1:0] buf0_q;
  logic [DATA_W-1:0] buf1_q;

  logic accept;
  logic noop;
  logic illegal;
  logic in_clint;

  function automatic int size_bytes(input logic [1:0] sz);
    case (sz)
      2'd3:    return 1;
      2'd2:    return 2;
      2'd1:    return 4;
      default: return 8;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  // An 8-byte zero-extended load encoding doubles as the no-op
  assign noop      = !req_wen && (req_memop == 3'b000);
  assign illegal   = (req_memop[1:0] == 2'b00) && (DATA_W == 32) && !noop;
  assign in_clint  = (req_addr >= CLINT_BASE) && (req_addr <= CLINT_END);

  int                off_i;
  int                n_i;
  logic              split;
  logic [DW2-1:0]    wide;
  logic [B2-1:0]     mask2;
  logic [DATA_W-1:0] low;
  logic [DATA_W-1:0] keep;
  logic              sbit;
  logic [DATA_W-1:0] ext_res;

  // Beat formation from the latched request and load reassembly from the two beat buffers
  always_comb begin
    off_i = int'(addr_q[OFFW-1:0]);
    n_i   = size_bytes(memop_q[1:0]);
    split = (off_i + n_i) > B;
    wide  = {{DATA_W{1'b0}}, wdata_q} << (8 * off_i);
    mask2 = B2'((1 << n_i) - 1) << off_i;
    low   = DATA_W'({buf1_q, buf0_q} >> (8 * off_i));
    if (8 * n_i >= DATA_W) begin
      keep = '1;
    end else begin
      keep = (DATA_W'(1) << (8 * n_i)) - DATA_W'(1);
    end
    // keep ^ (keep >> 1) isolates the top kept bit, i.e. the sign bit of the access
    sbit    = memop_q[2] & (|(low & (keep ^ (keep >> 1))));
    ext_res = (low & keep) | (sbit ? ~keep : '0);
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_wen       = mem_req_valid && wen_q;
  assign mem_addr      = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}} + (k_q ? ADDR_W'(B) : '0);
  assign mem_wdata     = mem_wen ? (k_q ? wide[DW2-1:DATA_W] : wide[DATA_W-1:0]) : '0;
  assign mem_wmask     = mem_wen ? (k_q ? mask2[B2-1:B] : mask2[B-1:0]) : '0;
  assign resp_valid    = (state_q == DONE);
  assign resp_err      = resp_valid && err_q;
  assign resp_rdata    = resp_valid ? ext_res : '0;
  assign clint_we      = clint_we_q;
  assign clint_re      = clint_re_q;

  // Next-state logic: accept, issue beat, await response, report completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = (noop || illegal) ? DONE : REQ;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_resp_valid) state_d = (split && !k_q) ? REQ : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counter, read buffers and CLINT strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      memop_q    <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      k_q        <= 1'b0;
      err_q      <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      clint_we_q <= 1'b0;
      clint_re_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clint_we_q <= 1'b0;
      clint_re_q <= 1'b0;
      if (accept) begin
        addr_q     <= req_addr;
        memop_q    <= req_memop;
        wen_q      <= req_wen;
        wdata_q    <= req_wdata;
        k_q        <= 1'b0;
        err_q      <= illegal;
        buf0_q     <= '0;
        buf1_q     <= '0;
        clint_we_q <= in_clint && req_wen && !illegal;
        clint_re_q <= in_clint && !req_wen && !noop && !illegal;
      end
      if ((state_q == WAIT) && mem_resp_valid) begin
        if (k_q) buf1_q <= mem_rdata;
        else     buf0_q <= mem_rdata;
        if (split && !k_q) k_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lsu_split_mem.sv
// Directed bench for lsu_split_mem with a cycle-stepped bus responder.
// Vectors carry hand-computed beats, results, latencies and CLINT strobe counts.
// Reset state and reset-during-split are covered by hand-written sequences.
module tb_lsu_split_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_memop;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic        clint_we;
  logic        clint_re;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_split_mem dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_memop(req_memop), .req_wen(req_wen), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .clint_we(clint_we), .clint_re(clint_re)
  );

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  memop;
    logic        wen;
    logic [63:0] wdata;
    int          stall;   // cycles mem_req_ready is held low on beat 0
    logic [63:0] a0;      // beat-0 address; beat 1 is a0 + 8
    logic [7:0]  m0;
    logic [63:0] d0;
    logic [7:0]  m1;
    logic [63:0] d1;
    logic [63:0] r0;      // bus read data returned for beat 0 / beat 1
    logic [63:0] r1;
    int          beats;
    int          lat;     // cycles from acceptance to resp_valid
    logic [63:0] exp;
    int          we_n;
    int          re_n;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          nbeats;
    int          stall;
    int          lat;
    int          we_cnt;
    int          re_cnt;
    bit          got;
    bit          resp_pend;
    logic [63:0] pend_data;
    @(negedge clk);
    chk($sformatf("v%0d req_ready_idle", id), 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_memop = v.memop;
    req_wen   = v.wen;
    req_wdata = v.wdata;
    nbeats = 0; stall = 0; lat = 0; we_cnt = 0; re_cnt = 0; got = 1'b0; resp_pend = 1'b0;
    pend_data = '0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      req_valid      = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (resp_pend) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = pend_data;
        resp_pend      = 1'b0;
      end
      if (cyc == 1) chk($sformatf("v%0d req_ready_busy", id), 64'(req_ready), 64'd0);
      if (clint_we) we_cnt++;
      if (clint_re) re_cnt++;
      if (clint_we || clint_re) chk($sformatf("v%0d clint_cycle", id), 64'(cyc), 64'd1);
      if (mem_req_valid) begin
        chk($sformatf("v%0d b%0d addr", id, nbeats), mem_addr, (nbeats == 0) ? v.a0 : v.a0 + 64'd8);
        chk($sformatf("v%0d b%0d data", id, nbeats), mem_wdata, (nbeats == 0) ? v.d0 : v.d1);
        chk($sformatf("v%0d b%0d mask", id, nbeats), 64'(mem_wmask), 64'((nbeats == 0) ? v.m0 : v.m1));
        chk($sformatf("v%0d b%0d wen", id, nbeats), 64'(mem_wen), 64'(v.wen));
        if (nbeats == 0 && stall < v.stall) begin
          stall++;
        end else begin
          mem_req_ready = 1'b1;
          resp_pend     = 1'b1;
          pend_data     = (nbeats == 0) ? v.r0 : v.r1;
          nbeats++;
        end
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = cyc;
        chk($sformatf("v%0d rdata", id), resp_rdata, v.exp);
        chk($sformatf("v%0d err", id), 64'(resp_err), 64'd0);
      end
    end
    chk($sformatf("v%0d resp_seen", id), 64'(got), 64'd1);
    chk($sformatf("v%0d latency", id), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d beats", id), 64'(nbeats), 64'(v.beats));
    chk($sformatf("v%0d clint_we_cnt", id), 64'(we_cnt), 64'(v.we_n));
    chk($sformatf("v%0d clint_re_cnt", id), 64'(re_cnt), 64'(v.re_n));
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk($sformatf("v%0d resp_pulse", id), 64'(resp_valid), 64'd0);
    chk($sformatf("v%0d req_ready_after", id), 64'(req_ready), 64'd1);
  endtask

  initial begin
    //        addr              memop   wen   wdata                  st a0                m0     d0                      m1     d1        r0                      r1                     bt lat exp                     we re
    vecs[0]  = '{64'h8000_0008, 3'b100, 1'b0, 64'h0,                 0, 64'h8000_0008, 8'h00, 64'h0,                  8'h00, 64'h0,    64'h1122_3344_5566_7788, 64'h0,                 1, 3, 64'h1122_3344_5566_7788, 0, 0};
    vecs[1]  = '{64'h8000_0003, 3'b111, 1'b0, 64'h0,                 0, 64'h8000_0000, 8'h00, 64'h0,                  8'h00, 64'h0,    64'h0000_0000_8000_0000, 64'h0,                 1, 3, 64'hFFFF_FFFF_FFFF_FF80, 0, 0};
    vecs[2]  = '{64'h8000_0003, 3'b011, 1'b0, 64'h0,                 0, 64'h8000_0000, 8'h00, 64'h0,                  8'h00, 64'h0,    64'h0000_0000_8000_0000, 64'h0,                 1, 3, 64'h0000_0000_0000_0080, 0, 0};
    vecs[3]  = '{64'h8000_0006, 3'b001, 1'b1, 64'hAABB_CCDD,         3, 64'h8000_0000, 8'hC0, 64'hCCDD_0000_0000_0000, 8'h03, 64'hAABB, 64'h0,                  64'h0,                 2, 8, 64'h0,                  0, 0};
    vecs[4]  = '{64'h8000_000F, 3'b010, 1'b0, 64'h0,                 0, 64'h8000_0008, 8'h00, 64'h0,                  8'h00, 64'h0,    64'hEE00_0000_0000_0000, 64'h0000_0000_0000_00FF, 2, 5, 64'h0000_0000_0000_FFEE, 0, 0};
    vecs[5]  = '{64'h0200_BFF8, 3'b000, 1'b1, 64'h0123_4567_89AB_CDEF, 0, 64'h0200_BFF8, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0,  64'h0,                  64'h0,                 1, 3, 64'h0,                  1, 0};
    vecs[6]  = '{64'h8000_0000, 3'b000, 1'b0, 64'h0,                 0, 64'h0,         8'h00, 64'h0,                  8'h00, 64'h0,    64'h0,                  64'h0,                 0, 1, 64'h0,                  0, 0};
    vecs[7]  = '{64'h0200_0000, 3'b001, 1'b0, 64'h0,                 0, 64'h0200_0000, 8'h00, 64'h0,                  8'h00, 64'h0,    64'hDEAD_BEEF_8765_4321, 64'h0,                 1, 3, 64'h0000_0000_8765_4321, 0, 1};
    vecs[8]  = '{64'h8000_0014, 3'b101, 1'b0, 64'h0,                 0, 64'h8000_0010, 8'h00, 64'h0,                  8'h00, 64'h0,    64'h9876_5432_0000_0000, 64'h0,                 1, 3, 64'hFFFF_FFFF_9876_5432, 0, 0};
    vecs[9]  = '{64'h8000_0022, 3'b010, 1'b1, 64'h1234,              0, 64'h8000_0020, 8'h0C, 64'h0000_0000_1234_0000, 8'h00, 64'h0,  64'h0,                  64'h0,                 1, 3, 64'h0,                  0, 0};
    vecs[10] = '{64'h0200_BFFF, 3'b011, 1'b0, 64'h0,                 0, 64'h0200_BFF8, 8'h00, 64'h0,                  8'h00, 64'h0,    64'h7F00_0000_0000_0000, 64'h0,                 1, 3, 64'h0000_0000_0000_007F, 0, 1};
    vecs[11] = '{64'h0200_C000, 3'b111, 1'b0, 64'h0,                 0, 64'h0200_C000, 8'h00, 64'h0,                  8'h00, 64'h0,    64'h0000_0000_0000_00AB, 64'h0,                 1, 3, 64'hFFFF_FFFF_FFFF_FFAB, 0, 0};
    vecs[12] = '{64'h8000_0104, 3'b100, 1'b0, 64'h0,                 1, 64'h8000_0100, 8'h00, 64'h0,                  8'h00, 64'h0,    64'h4433_2211_0000_0000, 64'h0000_0000_8877_6655, 2, 6, 64'h8877_6655_4433_2211, 0, 0};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_memop = '0; req_wen = 1'b0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst resp_valid", 64'(resp_valid), 64'd0);
    chk("rst resp_err", 64'(resp_err), 64'd0);
    chk("rst resp_rdata", resp_rdata, 64'd0);
    chk("rst mem_wmask", 64'(mem_wmask), 64'd0);
    chk("rst clint", 64'({clint_we, clint_re}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Reset while waiting for the second beat of a split load
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h8000_000F; req_memop = 3'b010; req_wen = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid b0 valid", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hEE00_0000_0000_0000;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("mid b1 valid", 64'(mem_req_valid), 64'd1);
    chk("mid b1 addr", mem_addr, 64'h8000_0010);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("mid rst resp_valid", 64'(resp_valid), 64'd0);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'hFF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("mid idle req_ready", 64'(req_ready), 64'd1);
    chk("mid stray mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("mid stray resp_valid", 64'(resp_valid), 64'd0);
    begin
      int stray;
      stray = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (resp_valid || mem_req_valid) stray++;
      end
      chk("mid quiet", 64'(stray), 64'd0);
    end

    // Unit still works normally after the aborted request
    run_vec(vecs[0], 100);
    run_vec(vecs[4], 104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
